// File: rtl/window_buffer_pkg.sv
// Shared accelerator types: pixel format and default frame geometry,
// common to the window buffer and the pooling stage.
package window_buffer_pkg;

   typedef logic signed [7:0] pixel_t;

   localparam int IMG_W_DEFAULT = 8;
   localparam int IMG_H_DEFAULT = 8;
   localparam int WIN_TAPS      = 9;

endpackage

// File: rtl/window_buffer_row_delay.sv
// One-row pixel delay line: dout is the pixel accepted IMG_W enables ago,
// i.e. the same column of the previous row.
module row_delay
   import window_buffer_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEFAULT
) (
   input  logic              clk,
   input  logic              en,
   input  logic signed [7:0] din,
   output logic signed [7:0] dout
);

   pixel_t taps_q [IMG_W];

   // NOTE: the delay storage has no reset on purpose; stale contents are never
   // observed because the window stays suppressed until two fresh rows have passed.
   always_ff @(posedge clk) begin
      if (en) begin
         taps_q[0] <= din;
         for (int i = 1; i < IMG_W; i++) begin
            taps_q[i] <= taps_q[i-1];
         end
      end
   end

   assign dout = taps_q[IMG_W-1];

endmodule

// File: rtl/window_buffer.sv
// 3x3 sliding window over a raster pixel stream, built from two row_delay lines.
// Optional build macro WINBUF_STRIDE2_EN: emit windows only at even row and column.
module window_buffer
   import window_buffer_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEFAULT,
   parameter int IMG_H = IMG_H_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic signed [7:0] data_in,
   output logic signed [7:0] data_out0,
   output logic signed [7:0] data_out1,
   output logic signed [7:0] data_out2,
   output logic signed [7:0] data_out3,
   output logic signed [7:0] data_out4,
   output logic signed [7:0] data_out5,
   output logic signed [7:0] data_out6,
   output logic signed [7:0] data_out7,
   output logic signed [7:0] data_out8,
   output logic              valid_out,
   output logic              frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   localparam logic [0:0] ST_FILL   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [0:0]    state_q, state_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;
   pixel_t        win_q [WIN_TAPS];
   pixel_t        win_d [WIN_TAPS];

   pixel_t above1, above2;
   pixel_t left1_q [3];
   pixel_t left2_q [3];

   logic row_wrap, frame_wrap, stride_ok, emit;

   row_delay #(.IMG_W(IMG_W)) u_line1 (
      .clk  (clk),
      .en   (valid_in),
      .din  (data_in),
      .dout (above1)
   );

   row_delay #(.IMG_W(IMG_W)) u_line2 (
      .clk  (clk),
      .en   (valid_in),
      .din  (above1),
      .dout (above2)
   );

`ifdef WINBUF_STRIDE2_EN
   assign stride_ok = ~row_q[0] & ~col_q[0];
`else
   assign stride_ok = 1'b1;
`endif

   assign row_wrap   = (col_q == COL_LAST);
   assign frame_wrap = row_wrap && (row_q == ROW_LAST);
   assign emit       = valid_in && (state_q == ST_STREAM) && (col_q >= CW'(2)) && stride_ok;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      state_d = state_q;
      if (valid_in) begin
         if (row_wrap) begin
            col_d = '0;
            row_d = frame_wrap ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
         case (state_q)
            ST_FILL:   if (row_wrap && row_q == RW'(1)) state_d = ST_STREAM;
            ST_STREAM: if (frame_wrap)                  state_d = ST_FILL;
            default:                                    state_d = ST_FILL;
         endcase
      end
   end

   // Window columns are col-2, col-1 and the column arriving with this pixel.
   always_comb begin
      for (int i = 0; i < WIN_TAPS; i++) begin
         win_d[i] = win_q[i];
      end
      if (emit) begin
         win_d[0] = left2_q[0]; win_d[1] = left1_q[0]; win_d[2] = above2;
         win_d[3] = left2_q[1]; win_d[4] = left1_q[1]; win_d[5] = above1;
         win_d[6] = left2_q[2]; win_d[7] = left1_q[2]; win_d[8] = data_in;
      end
      valid_d = emit;
      done_d  = valid_in && frame_wrap;
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q   <= '0;
         row_q   <= '0;
         state_q <= ST_FILL;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < WIN_TAPS; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         state_q <= state_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         win_q   <= win_d;
      end
   end

   always_ff @(posedge clk) begin
      if (valid_in) begin
         left2_q    <= left1_q;
         left1_q[0] <= above2;
         left1_q[1] <= above1;
         left1_q[2] <= data_in;
      end
   end

   assign data_out0  = win_q[0];
   assign data_out1  = win_q[1];
   assign data_out2  = win_q[2];
   assign data_out3  = win_q[3];
   assign data_out4  = win_q[4];
   assign data_out5  = win_q[5];
   assign data_out6  = win_q[6];
   assign data_out7  = win_q[7];
   assign data_out8  = win_q[8];
   assign valid_out  = valid_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_window_buffer.sv
// Self-checking bench for window_buffer: a 4x4 and a 5x5 instance checked
// against an image-array reference model; honours WINBUF_STRIDE2_EN.
module tb_window_buffer;

`ifdef WINBUF_STRIDE2_EN
   localparam bit STRIDE2 = 1'b1;
`else
   localparam bit STRIDE2 = 1'b0;
`endif

   typedef int arr9_t [9];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              v4, v5;
   logic signed [7:0] d4, d5;
   logic signed [7:0] o4 [9];
   logic signed [7:0] o5 [9];
   logic              vo4, fd4, vo5, fd5;

   int errors = 0;
   int checks = 0;

   int                dim [2] = '{4, 5};
   int                cnt [2];
   logic signed [7:0] img [2][5][5];
   logic [71:0]       exp_win [2];
   logic [72:0]       seen4 [$];
   logic [72:0]       seen5 [$];

   window_buffer #(.IMG_W(4), .IMG_H(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .valid_in(v4), .data_in(d4),
      .data_out0(o4[0]), .data_out1(o4[1]), .data_out2(o4[2]),
      .data_out3(o4[3]), .data_out4(o4[4]), .data_out5(o4[5]),
      .data_out6(o4[6]), .data_out7(o4[7]), .data_out8(o4[8]),
      .valid_out(vo4), .frame_done(fd4)
   );

   window_buffer #(.IMG_W(5), .IMG_H(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .valid_in(v5), .data_in(d5),
      .data_out0(o5[0]), .data_out1(o5[1]), .data_out2(o5[2]),
      .data_out3(o5[3]), .data_out4(o5[4]), .data_out5(o5[5]),
      .data_out6(o5[6]), .data_out7(o5[7]), .data_out8(o5[8]),
      .valid_out(vo5), .frame_done(fd5)
   );

   function automatic logic [71:0] pk(input arr9_t a);
      logic [71:0] w;
      int          v;
      w = '0;
      for (int i = 0; i < 9; i++) begin
         v = a[i];
         w[71-8*i -: 8] = v[7:0];
      end
      return w;
   endfunction

   function automatic logic [71:0] pack_dut(input int sel);
      logic [71:0] w;
      for (int i = 0; i < 9; i++) begin
         w[71-8*i -: 8] = (sel == 0) ? o4[i] : o5[i];
      end
      return w;
   endfunction

   task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive at the falling edge, advance the model, sample 1 ns after the rising edge.
   task automatic step(input int sel, input bit v, input int d);
      bit          emit, fdone;
      int          r, c, w, h, pv;
      logic [71:0] ew;
      @(negedge clk);
      v4 = (sel == 0) && v;
      v5 = (sel == 1) && v;
      d4 = 8'($urandom);
      d5 = 8'($urandom);
      if (sel == 0 && v) d4 = 8'(d);
      if (sel == 1 && v) d5 = 8'(d);
      emit  = 1'b0;
      fdone = 1'b0;
      if (v) begin
         w = dim[sel];
         h = dim[sel];
         r = cnt[sel] / w;
         c = cnt[sel] % w;
         img[sel][r][c] = 8'(d);
         emit  = (r >= 2) && (c >= 2) && (!STRIDE2 || (r % 2 == 0 && c % 2 == 0));
         fdone = (cnt[sel] == w * h - 1);
         if (emit) begin
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  pv = img[sel][r-2+i][c-2+j];
                  ew[71-8*(3*i+j) -: 8] = pv[7:0];
               end
            end
            exp_win[sel] = ew;
         end
         cnt[sel] = (cnt[sel] + 1) % (w * h);
      end
      @(posedge clk);
      #1;
      check("valid_out",  73'((sel == 0) ? vo4 : vo5), 73'(emit));
      check("frame_done", 73'((sel == 0) ? fd4 : fd5), 73'(fdone));
      check("window",     73'(pack_dut(sel)), 73'(exp_win[sel]));
      check("idle_valid", 73'((sel == 0) ? vo5 : vo4), 73'(0));
      if (sel == 0 && vo4) seen4.push_back({fd4, pack_dut(0)});
      if (sel == 1 && vo5) seen5.push_back({fd5, pack_dut(1)});
   endtask

   task automatic do_reset();
      @(negedge clk);
      v4 = 1'b0;
      v5 = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_valid4", 73'({vo4, fd4}), 73'(0));
      check("rst_win4",   73'(pack_dut(0)), 73'(0));
      check("rst_valid5", 73'({vo5, fd5}), 73'(0));
      check("rst_win5",   73'(pack_dut(1)), 73'(0));
      @(posedge clk);
      #1;
      check("rst_hold4", 73'({vo4, fd4}), 73'(0));
      @(negedge clk);
      rst_n = 1'b1;
      cnt = '{0, 0};
      exp_win[0] = '0;
      exp_win[1] = '0;
   endtask

   task automatic send_frame(input int sel, input int base, input bit gaps);
      for (int i = 0; i < dim[sel] * dim[sel]; i++) begin
         step(sel, 1'b1, base + i);
         if (gaps) step(sel, 1'b0, 0);
      end
   endtask

   logic [72:0] first44, last44, first55, last55, f2_first;

   initial begin
      rst_n = 1'b0;
      v4 = 1'b0; v5 = 1'b0; d4 = '0; d5 = '0;
      first44  = {1'b0, pk('{0, 1, 2, 4, 5, 6, 8, 9, 10})};
      last44   = STRIDE2 ? first44 : {1'b1, pk('{5, 6, 7, 9, 10, 11, 13, 14, 15})};
      first55  = {1'b0, pk('{-12, -11, -10, -7, -6, -5, -2, -1, 0})};
      last55   = {1'b1, pk('{0, 1, 2, 5, 6, 7, 10, 11, 12})};
      f2_first = {1'b0, pk('{100, 101, 102, 104, 105, 106, 108, 109, 110})};
      do_reset();

      // 4x4 frame, back-to-back pixels
      send_frame(0, 0, 1'b0);
      check("bb_count", 73'(seen4.size()), 73'(STRIDE2 ? 1 : 4));
      check("bb_first", seen4[0], first44);
      check("bb_last",  seen4[seen4.size()-1], last44);
      seen4.delete();

      // same frame with an idle cycle after every pixel
      send_frame(0, 0, 1'b1);
      check("gap_count", 73'(seen4.size()), 73'(STRIDE2 ? 1 : 4));
      check("gap_first", seen4[0], first44);
      check("gap_last",  seen4[seen4.size()-1], last44);
      seen4.delete();

      // two consecutive frames
      send_frame(0, 0, 1'b0);
      send_frame(0, 100, 1'b0);
      check("f2_count", 73'(seen4.size()), 73'(STRIDE2 ? 2 : 8));
      check("f2_first", seen4[STRIDE2 ? 1 : 4], f2_first);
      seen4.delete();

      // reset mid-frame after pixel 9, then a clean frame
      for (int i = 0; i < 10; i++) step(0, 1'b1, i);
      do_reset();
      send_frame(0, 0, 1'b0);
      check("rst_count", 73'(seen4.size()), 73'(STRIDE2 ? 1 : 4));
      check("rst_first", seen4[0], first44);
      check("rst_last",  seen4[seen4.size()-1], last44);
      seen4.delete();

      // 5x5 frame of signed pixels -12..12
      send_frame(1, -12, 1'b0);
      check("s5_count", 73'(seen5.size()), 73'(STRIDE2 ? 4 : 9));
      check("s5_first", seen5[0], first55);
      check("s5_last",  seen5[seen5.size()-1], last55);
      seen5.delete();

      // random gaps and data on the 5x5 instance
      for (int i = 0; i < 300; i++) begin
         step(1, ($urandom % 10) < 6, int'($urandom_range(0, 255)) - 128);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/window_buffer.md
WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 SHALL have parameter IMG_W, default 8, meaning pixels per row (legal range 3..64).
REQ-002 SHALL have parameter IMG_H, default 8, meaning rows per frame (legal range 3..64).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port valid_in, input, 1 bit: data_in carries one pixel this cycle.
REQ-006 SHALL have port data_in, input, signed 8 bits: raster-order pixel.
REQ-007 SHALL have ports data_out0..data_out8, output, signed 8 bits each: 3x3 window, row-major, data_out0 top-left, data_out8 bottom-right.
REQ-008 SHALL have port valid_out, output, 1 bit: window on data_out0..8 is complete this cycle.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame.

Function
REQ-010 SHALL accept one pixel per cycle with valid_in=1 and SHALL ignore data_in when valid_in=0; it has no backpressure.
REQ-011 SHALL track col (0..IMG_W-1) and row (0..IMG_H-1) counters, advancing only on accepted pixels; col wraps to 0 and increments row; after (IMG_H-1, IMG_W-1) both wrap to 0.
REQ-012 SHALL hold two row delay lines of IMG_W pixels each, shifting only on accepted pixels.
REQ-013 SHALL run FSM states FILL (row<2), STREAM (row>=2), with FILL->STREAM on the accept that makes row=2 and STREAM->FILL on the frame-wrap accept.
REQ-014 SHALL, when a pixel at (row,col) is accepted with row>=2 and col>=2, register the window of pixels (row-2..row, col-2..col) and assert valid_out for exactly the next cycle.
REQ-015 SHALL keep valid_out=0 for accepts with row<2 or col<2; windows SHALL never span a row or frame boundary.
REQ-016 SHALL hold data_out0..8 unchanged while valid_out=0.
REQ-017 SHALL have latency of exactly 1 cycle from the accepting edge of the bottom-right pixel to valid_out=1.
REQ-018 SHALL pass signed values bit-exact (no saturation, no sign change).
REQ-019 SHALL assert frame_done for one cycle, concurrently with that pixel's valid_out, after accepting (IMG_H-1, IMG_W-1).
REQ-020 SHALL tolerate arbitrary valid_in gaps at any point, including mid-row, with identical output window contents.

Reset
REQ-021 SHALL, while rst_n=0, force valid_out=0, frame_done=0, data_out0..8=0, col=0, row=0, FSM=FILL.
REQ-022 SHALL not clear the row delay lines on reset; they are stale by design since FILL suppresses output until overwritten.
REQ-023 SHALL, on reset mid-frame, restart at (0,0) with the next accepted pixel and emit no window containing pre-reset pixels.

Configuration
REQ-024 SHALL, with WINBUF_STRIDE2_EN defined, emit windows only when row and col of the bottom-right pixel are both even (stride 2); without it, stride is 1 per REQ-014.
REQ-025 SHALL leave frame_done and all other behaviour identical in both builds.

Structure
REQ-026 SHALL take pixel_t (signed 8-bit) and default IMG_W/IMG_H constants from the shared accelerator package also used by the pooling stage.
REQ-027 SHALL implement each row delay line as one sub-module, row_delay, instantiated twice, parameterised by IMG_W, with ports clk, en, din, dout.
REQ-028 SHALL connect data_out0..8 and valid_out directly to the pooling stage's data_in0..8 and valid_in with no glue.

Verification
REQ-029 SHALL cover: IMG_W=4, IMG_H=4, pixels 0..15 back-to-back -> 4 windows; first window after pixel 10 = 0,1,2,4,5,6,8,9,10; last = 5,6,7,9,10,11,13,14,15 with frame_done.
REQ-030 SHALL cover: same stream with valid_in=0 every other cycle -> identical 4 windows, each 1 cycle after its bottom-right accept.
REQ-031 SHALL cover: two consecutive frames, second frame pixels 100..115 -> first window of frame 2 = 100,101,102,104,105,106,108,109,110; no window mixes frames.
REQ-032 SHALL cover: rst_n pulsed low after pixel 9 then pixels 0..15 -> valid_out stays 0 through reset; then the 4 windows of REQ-029.
REQ-033 SHALL cover: IMG_W=5, IMG_H=5, pixels -12..12 -> 9 windows, first = -12,-11,-10,-7,-6,-5,-2,-1,0; with WINBUF_STRIDE2_EN -> 4 windows at bottom-right (2,2),(2,4),(4,2),(4,4).
